// File: rtl/wb_uart_lite_if.sv
// Wishbone B4 classic bus bundle for the lite UART slave port.
// master drives cyc/stb/adr/we/sel/dat_i; slave returns dat_o/ack_o.
interface wb_uart_lite_if;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] adr_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wb_uart_lite.sv
// Wishbone B4 classic UART slave, 8N1: TX FIFO, single-byte RX holding
// register, programmable baud divisor, level interrupt.
// Ports: clk_i/rst_i (sync, active-high), wb (slave bus bundle),
//        irq_o (level irq), rx_i (async serial in), tx_o (serial out).
module wb_uart_lite #(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned TX_DEPTH    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_uart_lite_if.slave wb,
  output logic          irq_o,
  input  logic          rx_i,
  output logic          tx_o
);
  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_e;

  // Registers
  logic [15:0] baud;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun, frame_err, tx_ovf;
  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  state_e      tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic        tx_o_n, tx_pop;

  state_e      rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic        rx_s1, rx_s2, rx_d, rx_done, rx_ferr;

  // Bus decode
  logic        req, wr_tx, rd_rx, wr_st, wr_baud, push;
  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_rd;
  logic [15:0] baud_w;
  logic [31:0] status, rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wb.adr_i[31:4], wb.adr_i[1:0], wb.sel_i[3:2], wb.dat_i[31:16]};

  assign req     = wb.cyc_i & wb.stb_i & ~wb.ack_o;
  assign wr_tx   = req & wb.we_i & (wb.adr_i[3:2] == 2'd0) & wb.sel_i[0];
  assign rd_rx   = req & ~wb.we_i & (wb.adr_i[3:2] == 2'd1);
  assign wr_st   = req & wb.we_i & (wb.adr_i[3:2] == 2'd2);
  assign wr_baud = req & wb.we_i & (wb.adr_i[3:2] == 2'd3);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_rd    = mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = wr_tx & (~fifo_full | tx_pop);

  assign baud_w = {wb.sel_i[1] ? wb.dat_i[15:8] : baud[15:8],
                   wb.sel_i[0] ? wb.dat_i[7:0]  : baud[7:0]};

  assign status = {25'd0, tx_ovf, frame_err, rx_overrun, rx_valid,
                   (tx_state != S_IDLE), fifo_empty, fifo_full};

  // Read mux
  always_comb begin
    rd_data = 32'd0;
    case (wb.adr_i[3:2])
      2'd1:    rd_data = {24'd0, rx_byte};
      2'd2:    rd_data = status;
      2'd3:    rd_data = {16'd0, baud};
      default: rd_data = 32'd0;
    endcase
  end

  // TX next-state: divisor is latched whenever a byte is popped into the shifter.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_sh_n    = tx_sh;
    tx_idx_n   = tx_idx;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = fifo_rd;
          tx_div_n   = baud;
          tx_cnt_n   = baud - 16'd1;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n   = tx_div - 16'd1;
          tx_idx_n   = 3'd0;
          tx_state_n = S_DATA;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = tx_div - 16'd1;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_idx == 3'd7) tx_state_n = S_STOP;
          else                tx_idx_n   = tx_idx + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt == 16'd0) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = fifo_rd;
            tx_div_n   = baud;
            tx_cnt_n   = baud - 16'd1;
            tx_state_n = S_START;
          end else begin
            tx_state_n = S_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    case (tx_state_n)
      S_START: tx_o_n = 1'b0;
      S_DATA:  tx_o_n = tx_sh_n[0];
      default: tx_o_n = 1'b1;
    endcase
  end

  // TX state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_sh    <= 8'd0;
      tx_idx   <= 3'd0;
      tx_o     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_sh    <= tx_sh_n;
      tx_idx   <= tx_idx_n;
      tx_o     <= tx_o_n;
    end
  end

  // RX next-state: start is confirmed half a bit after the edge, then mid-bit sampling.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_sh_n    = rx_sh;
    rx_idx_n   = rx_idx;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_d && !rx_s2) begin
          rx_div_n   = baud;
          rx_cnt_n   = (baud >> 1) - 16'd1;
          rx_state_n = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == 16'd0) begin
          if (rx_s2) begin
            rx_state_n = S_IDLE;
          end else begin
            rx_cnt_n   = rx_div - 16'd1;
            rx_idx_n   = 3'd0;
            rx_state_n = S_DATA;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_cnt_n = rx_div - 16'd1;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_idx == 3'd7) rx_state_n = S_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_done    = rx_s2;
          rx_ferr    = ~rx_s2;
          rx_state_n = S_IDLE;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // RX synchronizer, edge-detect stage and state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= 16'd0;
      rx_sh    <= 8'd0;
      rx_idx   <= 3'd0;
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_sh    <= rx_sh_n;
      rx_idx   <= rx_idx_n;
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wb.dat_i[7:0];
  end

  // Bus response, status flags, FIFO pointers, divisor, interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb.ack_o   <= 1'b0;
      wb.dat_o   <= 32'd0;
      irq_o      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      baud       <= 16'(DEFAULT_DIV);
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_ovf     <= 1'b0;
    end else begin
      wb.ack_o <= req;
      if (req) wb.dat_o <= rd_data;
      irq_o <= rx_valid | frame_err | rx_overrun;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_baud) baud <= (baud_w < 16'd4) ? 16'd4 : baud_w;
      // A byte completing alongside an RXDATA read wins over the clear.
      if (rx_done) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      rx_overrun <= (rx_overrun & ~(wr_st & wb.dat_i[4])) | (rx_done & rx_valid & ~rd_rx);
      frame_err  <= (frame_err  & ~(wr_st & wb.dat_i[5])) | rx_ferr;
      tx_ovf     <= (tx_ovf     & ~(wr_st & wb.dat_i[6])) | (wr_tx & fifo_full & ~tx_pop);
    end
  end
endmodule

// File: tb/tb_wb_uart_lite.sv
// Self-checking bench for wb_uart_lite: register vector table, directed
// multi-cycle sequences, and randomized TX/RX traffic checked by a serial
// line decoder and byte scoreboard.
module tb_wb_uart_lite;
  localparam int unsigned DEF_DIV = 434;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_line = 1'b1;
  logic irq;
  logic tx;

  wb_uart_lite_if wb_bus ();

  wb_uart_lite #(.DEFAULT_DIV(DEF_DIV), .TX_DEPTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb_bus),
    .irq_o (irq),
    .rx_i  (rx_line),
    .tx_o  (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One classic-cycle transfer; the request is sampled at the first posedge.
  task automatic wb_xfer(input logic [1:0] r, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    wb_bus.cyc_i = 1'b1;
    wb_bus.stb_i = 1'b1;
    wb_bus.adr_i = {28'h0, r, 2'b00};
    wb_bus.we_i  = we;
    wb_bus.sel_i = sel;
    wb_bus.dat_i = wd;
    @(posedge clk);
    @(negedge clk);
    chk("ack", {31'd0, wb_bus.ack_o}, 32'd1);
    rd = wb_bus.dat_o;
    wb_bus.cyc_i = 1'b0;
    wb_bus.stb_i = 1'b0;
    wb_bus.we_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(r, 1'b1, 4'hF, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(r, 1'b0, 4'hF, 32'd0, v);
    chk(name, v, exp);
  endtask

  // Drive one 8N1 frame (optionally with a bad stop bit), then one idle bit time.
  task automatic send_rx(input logic [7:0] b, input int unsigned div, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (div) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  // Serial line decoder: finds start bits on tx and samples each bit mid-way.
  int unsigned mon_div = DEF_DIV;
  bit          mon_en  = 1'b1;
  logic [7:0]  got_q[$];
  int unsigned start_q[$];
  logic [7:0]  exp_q[$];

  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    int unsigned div, t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && tx === 1'b0) begin
        t0  = cycle;
        div = mon_div;
        repeat (div / 2) @(negedge clk);
        if (mon_en) chk("tx_start_bit", {31'd0, tx}, 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (div) @(negedge clk);
          b[k] = tx;
        end
        repeat (div) @(negedge clk);
        if (mon_en) begin
          chk("tx_stop_bit", {31'd0, tx}, 32'd1);
          got_q.push_back(b);
          start_q.push_back(t0);
        end
      end
      prev = tx;
    end
  end

  task automatic drain_and_compare(input string name);
    int unsigned w;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({name, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
    start_q.delete();
  endtask

  typedef struct {
    logic [1:0]  r;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin : wd
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  frame;
    int unsigned div, n;
    logic [7:0]  b;

    wb_bus.cyc_i = 1'b0;
    wb_bus.stb_i = 1'b0;
    wb_bus.adr_i = 32'd0;
    wb_bus.we_i  = 1'b0;
    wb_bus.sel_i = 4'h0;
    wb_bus.dat_i = 32'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, wb_bus.ack_o}, 32'd0);
    chk("rst_dat", wb_bus.dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tx",  {31'd0, tx}, 32'd1);
    rst = 1'b0;

    // Register vectors: {reg, we, sel, wdata, expected read}
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'd434});
    vecs.push_back('{2'd3, 1'b1, 4'hF, 32'hFFFF_0002,  32'h0});
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'h0004});
    vecs.push_back('{2'd3, 1'b1, 4'h1, 32'h0000_1234,  32'h0});
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'h0034});
    vecs.push_back('{2'd3, 1'b1, 4'h2, 32'h0000_1200,  32'h0});
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'h1234});
    vecs.push_back('{2'd3, 1'b1, 4'h3, 32'h0000_0003,  32'h0});
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'h0004});
    vecs.push_back('{2'd3, 1'b1, 4'h1, 32'h0000_0001,  32'h0});
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'h0004});
    vecs.push_back('{2'd0, 1'b0, 4'hF, 32'h0,          32'h0});
    vecs.push_back('{2'd1, 1'b1, 4'hF, 32'h0000_00FF,  32'h0});
    vecs.push_back('{2'd1, 1'b0, 4'hF, 32'h0,          32'h0});
    vecs.push_back('{2'd2, 1'b0, 4'hF, 32'h0,          32'h0000_0002});
    vecs.push_back('{2'd2, 1'b1, 4'hF, 32'h0000_007F,  32'h0});
    vecs.push_back('{2'd2, 1'b0, 4'hF, 32'h0,          32'h0000_0002});
    vecs.push_back('{2'd3, 1'b1, 4'hF, 32'h0000_0008,  32'h0});
    vecs.push_back('{2'd3, 1'b0, 4'hF, 32'h0,          32'h0008});
    for (int i = 0; i < vecs.size(); i++) begin
      wb_xfer(vecs[i].r, vecs[i].we, vecs[i].sel, vecs[i].wd, v);
      if (!vecs[i].we) chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // TX latency and waveform of 0x55 at 8 clocks per bit
    mon_div = 8;
    wr(2'd0, 32'h55);
    exp_q.push_back(8'h55);
    chk("tx_lat_high", {31'd0, tx}, 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk("tx55_wave", {31'd0, tx}, {31'd0, frame[i / 8]});
    end
    @(negedge clk);
    chk("tx55_idle", {31'd0, tx}, 32'd1);
    rd_chk("tx55_status", 2'd2, 32'h02);
    drain_and_compare("tx55");

    // FIFO fill while the shifter is busy, overflow, W1C and back-to-back drain
    wr(2'd0, 32'hC3);
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 8; i++) begin
      wr(2'd0, i);
      exp_q.push_back(8'(i));
    end
    rd_chk("fifo_full", 2'd2, 32'h05);
    wr(2'd0, 32'h08);
    rd_chk("fifo_ovf", 2'd2, 32'h45);
    wr(2'd2, 32'h40);
    rd_chk("ovf_clear", 2'd2, 32'h05);
    n = 0;
    while (got_q.size() < 9 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 9 && i < start_q.size(); i++)
      chk("b2b_gap", start_q[i] - start_q[i-1], 32'd80);
    drain_and_compare("fifo");

    // RX of 0xA5 at 16 clocks per bit
    wr(2'd3, 32'd16);
    send_rx(8'hA5, 16, 1'b1);
    rd_chk("rx_status", 2'd2, 32'h0A);
    chk("rx_irq", {31'd0, irq}, 32'd1);
    rd_chk("rx_data", 2'd1, 32'h0000_00A5);
    @(negedge clk);
    chk("rx_irq_drop", {31'd0, irq}, 32'd0);
    rd_chk("rx_status_clr", 2'd2, 32'h02);

    // 3-cycle glitch is rejected
    @(negedge clk);
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (60) @(negedge clk);
    rd_chk("glitch_status", 2'd2, 32'h02);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    // Bad stop bit
    send_rx(8'h3C, 16, 1'b0);
    rd_chk("ferr_status", 2'd2, 32'h22);
    chk("ferr_irq", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h20);
    rd_chk("ferr_clr", 2'd2, 32'h02);

    // Two bytes without a read
    send_rx(8'h11, 16, 1'b1);
    send_rx(8'h22, 16, 1'b1);
    rd_chk("ovr_status", 2'd2, 32'h1A);
    rd_chk("ovr_data", 2'd1, 32'h22);
    rd_chk("ovr_after_rd", 2'd2, 32'h12);
    wr(2'd2, 32'h10);
    rd_chk("ovr_clr", 2'd2, 32'h02);

    // Divisor clamp and 4-clock TX frame
    wr(2'd3, 32'd2);
    rd_chk("baud_clamp", 2'd3, 32'd4);
    mon_div = 4;
    wr(2'd0, 32'h96);
    exp_q.push_back(8'h96);
    drain_and_compare("baud4");

    // Randomized traffic against the scoreboard
    for (int it = 0; it < 12; it++) begin
      div = $urandom_range(4, 12);
      wr(2'd3, div);
      mon_div = div;
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        wr(2'd0, {24'd0, b});
        exp_q.push_back(b);
      end
      b = 8'($urandom);
      send_rx(b, div, 1'b1);
      wb_xfer(2'd2, 1'b0, 4'hF, 32'd0, v);
      chk("rnd_rx_status", v & 32'h78, 32'h08);
      rd_chk("rnd_rx_data", 2'd1, {24'd0, b});
      drain_and_compare("rnd_tx");
    end

    // Reset in the middle of data bit 3 of 0xF0
    wr(2'd3, 32'd8);
    mon_div = 8;
    mon_en  = 1'b0;
    wr(2'd0, 32'hF0);
    repeat (34) @(negedge clk);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    rd_chk("rst_mid_status", 2'd2, 32'h02);
    rd_chk("rst_mid_baud", 2'd3, DEF_DIV);
    repeat (100) @(negedge clk);
    chk("rst_mid_tx_idle", {31'd0, tx}, 32'd1);
    mon_en = 1'b1;
    got_q.delete();
    start_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_uart_lite.md
# wb_uart_lite

Wishbone B4 classic slave UART, 8N1, on the peripheral side of `wb_intercon`: it is reached through the `wb_uart_*` slave port and consumes the cycles the `wishbone_controller` master issues for the UART address window. It provides:
- an 8-entry transmit FIFO;
- a single-byte receive holding register;
- a software-programmable baud divisor;
- a level interrupt.

It drives the SoC `uart_tx` pin and samples `uart_rx`.

## Interface
Parameters:
- `DEFAULT_DIV`, default 434: reset value of the baud divisor, in clocks per bit (50 MHz / 115200).
- `TX_DEPTH`, default 8: TX FIFO depth; must be a power of 2.

Ports:
- `clk_i` — in, 1: single clock, rising edge.
- `rst_i` — in, 1: reset, synchronous, active-high.
- `cyc_i` — in, 1: Wishbone cycle.
- `stb_i` — in, 1: Wishbone strobe.
- `adr_i` — in, 32: byte address; only `[3:2]` are decoded.
- `we_i` — in, 1: write enable.
- `sel_i` — in, 4: byte selects.
- `dat_i` — in, 32: write data.
- `dat_o` — out, 32: read data.
- `ack_o` — out, 1: transfer acknowledge.
- `irq_o` — out, 1: interrupt, level.
- `rx_i` — in, 1: serial input (asynchronous).
- `tx_o` — out, 1: serial output.

## Operation
Register map, selected by `adr_i[3:2]`:
- 0x0 `TXDATA`, W:
  - With `sel_i[0]` set, pushes `dat_i[7:0]`.
  - If the FIFO is full, the byte is dropped and sticky `tx_ovf` is set.
  - Reads return 0.
- 0x4 `RXDATA`, R:
  - Returns `{24'b0, rx_byte}`.
  - Clears `rx_valid` in the ack cycle.
  - Writes are ignored.
- 0x8 `STATUS`, R and W1C:
  - Bits: `[0]` tx_full, `[1]` tx_empty, `[2]` tx_busy (shifter active), `[3]` rx_valid, `[4]` rx_overrun, `[5]` frame_err, `[6]` tx_ovf.
  - Writing 1 to bits `[6:4]` clears them; other bits are read-only.
- 0xC `BAUD`, R/W:
  - `[15:0]` is the divisor in clocks per bit; byte lanes are written per `sel_i[1:0]`.
  - A written value below 4 is stored as 4.
  - Takes effect at the next start bit, in either direction.

Bus:
- A request is `cyc_i & stb_i & ~ack_o`.
- `ack_o` is registered and asserted exactly the cycle after the request, for 1 cycle.
- Back-to-back requests therefore complete every 2 cycles.
- Write side effects and the `RXDATA` clear occur on the request cycle. `dat_o` is valid with `ack_o`; it holds its previous value otherwise.
- `err_o` and `rty_o` are not implemented; the interconnect ties them low.

TX FSM, states IDLE → START → DATA → STOP → IDLE:
- In IDLE with the FIFO non-empty: pop one entry, load the shifter, go to START.
- Each state lasts DIV cycles, as counted by a bit-counter that reloads DIV−1 and counts down to 0.
- DATA shifts out 8 bits, LSB first.
- From STOP: go back to START directly if the FIFO is non-empty, otherwise to IDLE. There is no idle gap between frames.
- `tx_o` = 1 in IDLE and STOP, 0 in START.

RX FSM, states IDLE → START → DATA → STOP:
- `rx_i` passes through a 2-flop synchronizer that resets to 1.
- IDLE: on a synchronized falling edge, wait DIV/2 (integer division) cycles, then resample in START.
- START: if the line is high, treat it as a glitch and return to IDLE with nothing recorded. Otherwise sample 8 data bits at DIV intervals (mid-bit), then the stop bit.
- Stop bit = 1:
  - Load `rx_byte` and set `rx_valid`.
  - If `rx_valid` was already set, also set `rx_overrun`; the new byte overwrites the old one.
- Stop bit = 0: set `frame_err`, discard the byte, and leave `rx_valid` unchanged.
- After STOP, return to IDLE. A new falling edge is detected from the first IDLE cycle.
- If a completing RX byte and a bus read of `RXDATA` fall in the same cycle, the new byte wins: `rx_valid` = 1 and `rx_overrun` is not set.

Interrupt: `irq_o = rx_valid | frame_err | rx_overrun`, registered.

## Timing
- Reset values:
  - `ack_o`=0, `dat_o`=0, `irq_o`=0, `tx_o`=1.
  - FIFO empty, both FSMs in IDLE, all status bits 0, BAUD=`DEFAULT_DIV`.
- Reset mid-frame aborts immediately: `tx_o`=1 in the cycle after `rst_i` is sampled high, and a partial RX byte is lost.
- TX latency, with TX idle and the FIFO empty, counting from the write request cycle at N:
  - the FIFO is non-empty at N+1;
  - the pop occurs at N+1;
  - `tx_o` falls at N+2.
- A frame is exactly 10·DIV cycles. Continuous frames follow with no gap.
- FIFO boundaries:
  - A push and a pop in the same cycle while full succeed; `tx_ovf` is not set.
  - While empty, a push is never popped in the same cycle.
- RX: `rx_valid` rises about 9.5·DIV + 3 cycles after the start edge arrives on `rx_i`. The +3 is 2 synchronizer stages plus 1 edge-detect stage.

## Test plan
- BAUD=8, write `TXDATA`=0x55:
  - `tx_o` falls 2 cycles after the request;
  - then shows 0,1,0,1,0,1,0,1,0,1 for 8 cycles each;
  - then stays high; `tx_empty`=1.
- Hold TX busy and write 9 bytes 0x00..0x08:
  - `tx_full`=1 after the 8th push that is not drained;
  - the 9th byte is dropped and `tx_ovf`=1;
  - writing STATUS 0x40 clears `tx_ovf`;
  - the bytes that were accepted (not dropped) are transmitted in order, back-to-back.
- BAUD=16, drive 0xA5 8N1 on `rx_i`:
  - `rx_valid` and `irq_o` set;
  - `RXDATA` reads 0x000000A5;
  - after the read, `rx_valid`=0 and `irq_o` drops the next cycle.
- With BAUD=16:
  - a 3-cycle low glitch on `rx_i` gives no `rx_valid` and no `frame_err`;
  - a frame with stop bit 0 gives `frame_err`=1 and leaves `rx_valid`=0;
  - receiving two bytes without a read gives `rx_overrun`=1, and `RXDATA` holds the second byte.
- Write BAUD=2: it reads back 4, and the next TX frame uses 4-cycle bits.
- Assert `rst_i` mid-TX at bit 3 of a frame:
  - `tx_o`=1 next cycle;
  - STATUS reads 0x02 (tx_empty only).
